// File: rtl/cache_mem_arbiter_pkg.sv
// mem_arb_pkg: shared state, owner and memory-op types for the cache memory arbiter.
package mem_arb_pkg;
  typedef enum logic {IDLE, SERVE} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;
endpackage

// File: rtl/cache_mem_arbiter_sat_counter.sv
// sat_counter: counter that increments on inc and holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin sharing of one memory port between I- and D-cache controllers.
module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_mem_valid,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_mem_valid,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              arb_busy,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);
  arb_state_t state;
  owner_t     owner, last_owner;
  mem_op_t    op;
  logic       req_i, req_d, pick_d, grant, serve;
  always_comb begin
    req_i  = i_mem_read | i_mem_write;
    req_d  = d_mem_read | d_mem_write;
    pick_d = req_d && (!req_i || last_owner == OWN_I);
    grant  = state == IDLE && (req_i || req_d);
    serve  = state == SERVE;
  end
  // Strobes derive only from registered state, so they are stable for the whole transaction.
  assign mem_read    = serve && op == OP_READ;
  assign mem_write   = serve && op == OP_WRITE;
  assign arb_busy    = serve;
  assign i_mem_valid = serve && owner == OWN_I && mem_valid;
  assign d_mem_valid = serve && owner == OWN_D && mem_valid;
  assign i_rdata     = i_mem_valid ? mem_rdata : '0;
  assign d_rdata     = d_mem_valid ? mem_rdata : '0;
  always_ff @(posedge clk)
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_D;
      op         <= OP_READ;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else if (grant) begin
      state      <= SERVE;
      owner      <= pick_d ? OWN_D : OWN_I;
      last_owner <= pick_d ? OWN_D : OWN_I;
      op         <= (pick_d ? d_mem_write : i_mem_write) ? OP_WRITE : OP_READ;
      mem_addr   <= pick_d ? d_addr : i_addr;
      mem_wdata  <= pick_d ? d_wdata : i_wdata;
    end else if (serve && mem_valid) state <= IDLE;
  sat_counter #(.CNT_W(CNT_W)) u_i_cnt (.clk(clk), .rst(rst), .inc(grant && !pick_d), .count(i_grant_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_d_cnt (.clk(clk), .rst(rst), .inc(grant && pick_d), .count(d_grant_cnt));
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed vector table plus hand sequences for reset, abort and round-robin.
module tb_cache_mem_arbiter;
  localparam logic [127:0] MRD = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] DWD = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [127:0] IWD = 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;
  logic clk = 0, rst = 1;
  logic i_mem_read = 0, i_mem_write = 0, d_mem_read = 0, d_mem_write = 0, mem_valid = 0;
  logic [31:0] i_addr = 0, d_addr = 0, mem_addr;
  logic [127:0] i_wdata = IWD, d_wdata = DWD, mem_rdata = MRD, i_rdata, d_rdata, mem_wdata;
  logic i_mem_valid, d_mem_valid, mem_read, mem_write, arb_busy;
  logic [15:0] i_grant_cnt, d_grant_cnt;
  int checks = 0, failures = 0;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_mem_valid(i_mem_valid), .i_rdata(i_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_mem_valid(d_mem_valid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .arb_busy(arb_busy),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic ir, iw; logic [31:0] ia;
    logic dr, dw; logic [31:0] da;
    logic mv;
    logic emr, emw; logic [31:0] ea;
    logic eiv, edv;
  } vec_t;
  vec_t v [29];

  initial begin
    int gi, ni, nd, cyc;
    v[0]  = '{0,0,32'h0,    0,0,32'h0,   0, 0,0,32'h0,    0,0};
    v[1]  = '{1,0,32'h1000, 0,0,32'h0,   0, 0,0,32'h0,    0,0};
    v[2]  = '{1,0,32'h1000, 0,0,32'h0,   0, 1,0,32'h1000, 0,0};
    v[3]  = '{1,0,32'h1000, 0,0,32'h0,   0, 1,0,32'h1000, 0,0};
    v[4]  = '{1,0,32'h1000, 0,0,32'h0,   0, 1,0,32'h1000, 0,0};
    v[5]  = '{1,0,32'h1000, 0,0,32'h0,   1, 1,0,32'h1000, 1,0};
    v[6]  = '{0,0,32'h0,    0,0,32'h0,   1, 0,0,32'h0,    0,0};
    v[7]  = '{1,0,32'h100,  1,0,32'h200, 0, 0,0,32'h0,    0,0};
    v[8]  = '{1,0,32'h100,  1,0,32'h200, 0, 1,0,32'h200,  0,0};
    v[9]  = '{1,0,32'h100,  1,0,32'h200, 1, 1,0,32'h200,  0,1};
    v[10] = '{1,0,32'h100,  0,0,32'h0,   0, 0,0,32'h0,    0,0};
    v[11] = '{1,0,32'h100,  0,0,32'h0,   0, 1,0,32'h100,  0,0};
    v[12] = '{1,0,32'h100,  0,0,32'h0,   1, 1,0,32'h100,  1,0};
    v[13] = '{0,0,32'h0,    0,0,32'h0,   0, 0,0,32'h0,    0,0};
    v[14] = '{0,0,32'h0,    1,1,32'h300, 0, 0,0,32'h0,    0,0};
    v[15] = '{0,0,32'h0,    1,1,32'h300, 0, 0,1,32'h300,  0,0};
    v[16] = '{0,0,32'h0,    1,1,32'h300, 1, 0,1,32'h300,  0,1};
    v[17] = '{0,0,32'h0,    1,0,32'h300, 0, 0,0,32'h0,    0,0};
    v[18] = '{0,0,32'h0,    1,0,32'h300, 0, 1,0,32'h300,  0,0};
    v[19] = '{0,0,32'h0,    1,0,32'h300, 1, 1,0,32'h300,  0,1};
    v[20] = '{0,0,32'h0,    0,0,32'h0,   0, 0,0,32'h0,    0,0};
    v[21] = '{0,0,32'h0,    1,0,32'h400, 0, 0,0,32'h0,    0,0};
    v[22] = '{0,0,32'h0,    1,0,32'h500, 0, 1,0,32'h400,  0,0};
    v[23] = '{0,0,32'h0,    1,0,32'h500, 1, 1,0,32'h400,  0,1};
    v[24] = '{0,0,32'h0,    0,0,32'h0,   0, 0,0,32'h0,    0,0};
    v[25] = '{1,0,32'h600,  0,0,32'h0,   0, 0,0,32'h0,    0,0};
    v[26] = '{0,0,32'h0,    0,0,32'h0,   0, 1,0,32'h600,  0,0};
    v[27] = '{0,0,32'h0,    0,0,32'h0,   1, 1,0,32'h600,  1,0};
    v[28] = '{0,0,32'h0,    0,0,32'h0,   0, 0,0,32'h0,    0,0};

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    #1;
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_cnt", i_grant_cnt, 0);
    chk("rst_d_cnt", d_grant_cnt, 0);
    @(negedge clk);

    foreach (v[k]) begin
      i_mem_read = v[k].ir; i_mem_write = v[k].iw; i_addr = v[k].ia;
      d_mem_read = v[k].dr; d_mem_write = v[k].dw; d_addr = v[k].da;
      mem_valid = v[k].mv;
      #1;
      chk($sformatf("v%0d_mem_read", k), mem_read, v[k].emr);
      chk($sformatf("v%0d_mem_write", k), mem_write, v[k].emw);
      chk($sformatf("v%0d_busy", k), arb_busy, v[k].emr | v[k].emw);
      chk($sformatf("v%0d_i_valid", k), i_mem_valid, v[k].eiv);
      chk($sformatf("v%0d_d_valid", k), d_mem_valid, v[k].edv);
      chk($sformatf("v%0d_i_rdata", k), i_rdata, v[k].eiv ? MRD : 128'h0);
      chk($sformatf("v%0d_d_rdata", k), d_rdata, v[k].edv ? MRD : 128'h0);
      if (v[k].emr | v[k].emw) chk($sformatf("v%0d_mem_addr", k), mem_addr, v[k].ea);
      if (v[k].emw) chk($sformatf("v%0d_mem_wdata", k), mem_wdata, DWD);
      @(negedge clk);
    end
    mem_valid = 0;
    #1;
    chk("tbl_i_cnt", i_grant_cnt, 3);
    chk("tbl_d_cnt", d_grant_cnt, 4);

    // reset during SERVE abandons the transaction and clears counters
    @(negedge clk);
    d_mem_read = 1; d_addr = 32'h700;
    @(negedge clk);
    #1 chk("abort_pre_read", mem_read, 1);
    rst = 1; d_mem_read = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("abort_mem_read", mem_read, 0);
    chk("abort_busy", arb_busy, 0);
    chk("abort_i_cnt", i_grant_cnt, 0);
    chk("abort_d_cnt", d_grant_cnt, 0);
    mem_valid = 1;
    #1;
    chk("abort_late_d_valid", d_mem_valid, 0);
    chk("abort_late_i_valid", i_mem_valid, 0);
    @(negedge clk);
    mem_valid = 0;
    #1 chk("abort_idle_busy", arb_busy, 0);

    // round-robin from reset: tie goes to I first, then strict alternation
    i_addr = 32'h100; d_addr = 32'h200;
    gi = 0; ni = 0; nd = 0; cyc = 0;
    @(negedge clk);
    while ((ni < 10 || nd < 10) && cyc < 200) begin
      i_mem_read = ni < 10; d_mem_read = nd < 10; mem_valid = 0;
      #1;
      if (mem_read) begin
        chk($sformatf("rr_grant%0d_addr", gi), mem_addr, gi % 2 ? 32'h200 : 32'h100);
        mem_valid = 1;
        #1;
        if (i_mem_valid) ni++;
        if (d_mem_valid) nd++;
        gi++;
      end
      @(negedge clk);
      cyc++;
    end
    i_mem_read = 0; d_mem_read = 0; mem_valid = 0;
    #1;
    chk("rr_grants", gi, 20);
    chk("rr_i_cnt", i_grant_cnt, 10);
    chk("rr_d_cnt", d_grant_cnt, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory port between the L1 instruction-cache and L1 data-cache miss/writeback controllers of the multicycle OTTER.
- Each cache controller drives its own mem_read/mem_write request and waits for mem_valid. The arbiter grants one requester at a time, registers its command, and forwards it to memory. It routes the completion pulse and read line back to the owner only.
- Arbitration is round-robin, with a write-before-read rule inside a single requester.
- Saturating grant counters are provided for performance debug.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, cache-line data width (4 words).
- CNT_W, 16, width of the saturating grant counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_mem_read  in  1  I-cache line-fill request (level, held until i_mem_valid)
- i_mem_write  in  1  I-cache writeback request (tie 0 if unused)
- i_addr  in  ADDR_W  I-cache line address
- i_wdata  in  LINE_W  I-cache writeback line
- i_mem_valid  out  1  one-cycle completion pulse to the I-cache
- i_rdata  out  LINE_W  read line to the I-cache
- d_mem_read, d_mem_write, d_addr, d_wdata, d_mem_valid, d_rdata: same as the i_* ports, for the D-cache
- mem_read  out  1  read strobe to memory (level, held until mem_valid)
- mem_write  out  1  write strobe to memory (level, held until mem_valid)
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  LINE_W  registered write line
- mem_valid  in  1  memory completion pulse, one cycle
- mem_rdata  in  LINE_W  memory read line, valid while mem_valid=1
- arb_busy  out  1  high while a transaction is outstanding
- i_grant_cnt  out  CNT_W  number of I-cache grants, saturating
- d_grant_cnt  out  CNT_W  number of D-cache grants, saturating

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, last_owner=D.
  - Counters=0.
  - mem_read=mem_write=0, arb_busy=0.
  - Both *_mem_valid=0.
  - mem_addr/mem_wdata=0.
- States:
  - IDLE: no transaction outstanding.
  - SERVE: transaction for the registered owner in flight.
- IDLE, requests evaluated combinationally (req_i = i_mem_read|i_mem_write, same for D):
  - Only one requester active: grant it.
  - Both active: grant the one that is not last_owner, so the I-cache wins the first tie after reset.
  - On grant at the posedge:
    - Register owner, addr and wdata.
    - Register op = WRITE if that requester's mem_write=1, else READ; a writeback always precedes the fill.
    - Set last_owner=owner, increment that counter (hold at all-ones), go to SERVE.
  - No request: stay in IDLE, all outputs 0.
- SERVE:
  - mem_read=(op==READ), mem_write=(op==WRITE).
  - mem_addr/mem_wdata come from registers only. They are stable for the whole transaction even if the requester's inputs change.
  - arb_busy=1.
  - When mem_valid=1:
    - Owner's *_mem_valid=mem_valid (combinational, same cycle); the other requester's valid=0.
    - Owner's *_rdata=mem_rdata; the non-owner's rdata=0.
    - Next state=IDLE.
- Latency:
  - Grant-to-memory strobe is 1 cycle (request seen in cycle N, mem strobe in N+1).
  - After mem_valid there is 1 turnaround cycle in IDLE before the next strobe.
  - Minimum spacing is 2 cycles between transactions.
- A requester that held both read and write gets its write served first. It then still holds its read and is re-arbitrated in IDLE, where round-robin now favours the other requester.
- A requester that drops its request mid-SERVE does not abort the memory op. The op completes and the valid pulse is still routed to it.
- A new request from the non-owner during SERVE waits; it is sampled only in IDLE.
- mem_valid while in IDLE is ignored: no *_mem_valid is asserted and the state is unchanged.
- rst during SERVE: strobes drop at the same posedge. Memory must tolerate an abandoned transaction.

Decomposition:
- Shared package mem_arb_pkg:
  - arb_state_t {IDLE, SERVE}
  - owner_t {OWN_I, OWN_D}
  - mem_op_t {OP_READ, OP_WRITE}
- Sub-module sat_counter (CNT_W, rst, clk, inc, count), instantiated twice.

Test Plan:
- Single I read: i_mem_read=1, i_addr=0x0000_1000 at cycle 0; memory returns mem_valid at cycle 4 with mem_rdata=0xDEADBEEF_... -> mem_read=1 with mem_addr=0x1000 during cycles 1-4; i_mem_valid=1 only in cycle 4 with i_rdata equal to mem_rdata; d_mem_valid=0 throughout; i_grant_cnt=1.
- Simultaneous requests after reset: I read 0x100 and D read 0x200 both at cycle 0 -> I is served first (mem_addr=0x100); D is granted in the IDLE cycle after I's valid (mem_addr=0x200); counters are 1/1.
- D write plus read together: d_mem_write=1 and d_mem_read=1, d_addr=0x300, d_wdata=0xA5A5...; I idle -> first transaction has mem_write=1 with mem_wdata=0xA5A5...; then, with d_mem_write=0, a mem_read to 0x300 follows; d_grant_cnt=2.
- Address stability: change d_addr from 0x400 to 0x500 during SERVE -> mem_addr stays 0x400 until mem_valid.
- Round-robin fairness: both requesters continuously reissue 10 reads -> grants alternate I,D,I,D...; final counters are 10 and 10.
- Reset mid-transaction: assert rst for 1 cycle during SERVE -> next cycle mem_read=0, arb_busy=0, counters=0; a mem_valid arriving afterwards produces no *_mem_valid.
